// File: rtl/rl_shi_reg_unload_pkg.sv
// Shared types and sizing for the serial-in / word-out result unloader.
package rl_shi_reg_unload_pkg;

    localparam int unsigned WORD_W_DFLT = 32;
    localparam int unsigned NWORDS_DFLT = 8;
    localparam int unsigned OP_W        = WORD_W_DFLT * NWORDS_DFLT;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_SHL1 = 2'd1,
        OP_SHRW = 2'd2,
        OP_FILL = 2'd3
    } core_op_e;

endpackage

// File: rtl/rl_shi_reg_unload_core.sv
// Operand-wide shift register: serial shift-left, word shift-right with zero fill, all-ones load.
module rl_shi_reg_core
    import rl_shi_reg_unload_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OP_BITS = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  core_op_e           op,
    input  logic               bit_in,
    output logic [OP_BITS-1:0] q
);

    logic [OP_BITS-1:0] reg_q;
    logic [OP_BITS-1:0] reg_d;

    always_comb begin
        reg_d = reg_q;
        unique case (op)
            OP_SHL1: reg_d = {reg_q[OP_BITS-2:0], bit_in};
            OP_SHRW: reg_d = {{WORD_W{1'b0}}, reg_q[OP_BITS-1:WORD_W]};
            OP_FILL: reg_d = '1;
            default: reg_d = reg_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/rl_shi_reg_unload.sv
// Collects an MSB-first serial result and returns it to the host as LS-word-first words.
module rl_shi_reg_unload
    import rl_shi_reg_unload_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DFLT,
    parameter int unsigned NWORDS = NWORDS_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              set,
    input  logic              bit_in,
    input  logic              bit_vld,
    output logic              bit_rdy,
    output logic [WORD_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              busy,
    output logic              done
);

    localparam int unsigned OP_BITS    = WORD_W * NWORDS;
    localparam int unsigned BIT_CNT_W  = $clog2(OP_BITS);
    localparam int unsigned WORD_CNT_W = $clog2(NWORDS);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(OP_BITS - 1);
    localparam logic [WORD_CNT_W-1:0] WORD_LAST = WORD_CNT_W'(NWORDS - 1);

    state_e                  state_q, state_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
    core_op_e                op;
    logic [OP_BITS-1:0]      shift_reg;
    logic                    word_hs;

    rl_shi_reg_core #(
        .WORD_W  (WORD_W),
        .OP_BITS (OP_BITS)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .op     (op),
        .bit_in (bit_in),
        .q      (shift_reg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_hs = (state_q == DRAIN) && dout_rdy;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        op         = OP_HOLD;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = COLLECT;
                    bit_cnt_d = '0;
                end else if (set) begin
                    op         = OP_FILL;
                    word_cnt_d = '0;
                    state_d    = DRAIN;
                end
            end
            COLLECT: begin
                if (bit_vld) begin
                    op        = OP_SHL1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d    = DRAIN;
                        word_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (word_hs) begin
                    op         = OP_SHRW;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == WORD_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_rdy  = (state_q == COLLECT);
        dout_vld = (state_q == DRAIN);
        busy     = (state_q != IDLE);
        done     = word_hs && (word_cnt_q == WORD_LAST);
        dout     = shift_reg[WORD_W-1:0];
    end

endmodule
